// File: rtl/dummy_accel_mt_unit.sv
// In-order ADD/SHL accelerator: issue buffer with commit/kill tracking feeding a 3-state exec FSM.
// Optional build macro DUMMY_ACCEL_PERF_CNT_EN adds perf_done_o / perf_killed_o counters.
module dummy_accel_mt_unit #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 12,
  parameter int ID_WIDTH  = 4,
  parameter int DEPTH     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic                 issue_op_i,
  input  logic [ID_WIDTH-1:0]  issue_id_i,
  input  logic [4:0]           issue_rd_i,
  input  logic [WIDTH-1:0]     issue_rs1_i,
  input  logic [IMM_WIDTH-1:0] issue_imm_i,
  input  logic                 commit_valid_i,
  input  logic [ID_WIDTH-1:0]  commit_id_i,
  input  logic                 commit_kill_i,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [ID_WIDTH-1:0]  result_id_o,
  output logic [4:0]           result_rd_o,
  output logic [WIDTH-1:0]     result_data_o,
  output logic                 result_we_o,
  output logic                 busy_o
`ifdef DUMMY_ACCEL_PERF_CNT_EN
  ,
  output logic [31:0]          perf_done_o,
  output logic [31:0]          perf_killed_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SH_W  = $clog2(WIDTH);

  // state  | meaning
  // IDLE   | wait for a resolved head: drop KILLED, start COMMITTED
  // EXEC   | ADD in one cycle, SHL one bit per cycle
  // RESP   | hold result until result_ready_i, then pop head
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] E_FREE = 2'd0;
  localparam logic [1:0] E_PEND = 2'd1;
  localparam logic [1:0] E_COMM = 2'd2;
  localparam logic [1:0] E_KILL = 2'd3;

  logic                 op_q  [DEPTH];
  logic [ID_WIDTH-1:0]  id_q  [DEPTH];
  logic [4:0]           rd_q  [DEPTH];
  logic [WIDTH-1:0]     rs1_q [DEPTH];
  logic [IMM_WIDTH-1:0] imm_q [DEPTH];
  logic [1:0]           st_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, scan_idx, cm_idx;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d, cm_state;
  logic [WIDTH-1:0] acc_q, acc_d, immx_q, immx_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic             opx_q, opx_d;
  logic             alloc, cm_hit, cm_new, pop_kill, pop_resp, pop;

  assign issue_ready_o = count_q < CNT_W'(DEPTH);
  assign alloc         = issue_valid_i && issue_ready_o;
  assign cm_state      = commit_kill_i ? E_KILL : E_COMM;

  // Scan from head so the oldest PENDING entry with a matching id wins.
  always_comb begin
    cm_hit   = 1'b0;
    cm_idx   = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (!cm_hit && commit_valid_i && st_q[scan_idx] == E_PEND &&
          id_q[scan_idx] == commit_id_i) begin
        cm_hit = 1'b1;
        cm_idx = scan_idx;
      end
    end
  end

  assign cm_new = commit_valid_i && !cm_hit && alloc && (issue_id_i == commit_id_i);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    immx_d   = immx_q;
    sh_d     = sh_q;
    opx_d    = opx_q;
    pop_kill = 1'b0;
    pop_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (st_q[head_q] == E_KILL) begin
          pop_kill = 1'b1;
        end else if (st_q[head_q] == E_COMM) begin
          acc_d   = rs1_q[head_q];
          immx_d  = WIDTH'($signed(imm_q[head_q]));
          sh_d    = imm_q[head_q][SH_W-1:0];
          opx_d   = op_q[head_q];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!opx_q) begin
          acc_d   = acc_q + immx_q;
          state_d = S_RESP;
        end else begin
          // Zero shift count still spends one EXEC cycle.
          if (sh_q != '0) begin
            acc_d = acc_q << 1;
            sh_d  = sh_q - SH_W'(1);
          end
          if (sh_q <= SH_W'(1)) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (result_ready_i) begin
          pop_resp = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop     = pop_kill || pop_resp;
  assign head_d  = pop ? head_q + PTR_W'(1) : head_q;
  assign tail_d  = alloc ? tail_q + PTR_W'(1) : tail_q;
  assign count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= 1'b0;
        id_q[i]  <= '0;
        rd_q[i]  <= '0;
        rs1_q[i] <= '0;
        imm_q[i] <= '0;
        st_q[i]  <= E_FREE;
      end
    end else begin
      if (alloc) begin
        op_q[tail_q]  <= issue_op_i;
        id_q[tail_q]  <= issue_id_i;
        rd_q[tail_q]  <= issue_rd_i;
        rs1_q[tail_q] <= issue_rs1_i;
        imm_q[tail_q] <= issue_imm_i;
        st_q[tail_q]  <= cm_new ? cm_state : E_PEND;
      end
      if (cm_hit) st_q[cm_idx] <= cm_state;
      if (pop) st_q[head_q] <= E_FREE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      acc_q   <= '0;
      immx_q  <= '0;
      sh_q    <= '0;
      opx_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      acc_q   <= acc_d;
      immx_q  <= immx_d;
      sh_q    <= sh_d;
      opx_q   <= opx_d;
    end
  end

  assign result_valid_o = (state_q == S_RESP);
  assign result_we_o    = result_valid_o;
  assign result_id_o    = result_valid_o ? id_q[head_q] : '0;
  assign result_rd_o    = result_valid_o ? rd_q[head_q] : '0;
  assign result_data_o  = result_valid_o ? acc_q : '0;
  assign busy_o         = (count_q != '0) || (state_q != S_IDLE);

`ifdef DUMMY_ACCEL_PERF_CNT_EN
  logic [31:0] perf_done_q, perf_killed_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_done_q   <= '0;
      perf_killed_q <= '0;
    end else begin
      if (pop_resp) perf_done_q <= perf_done_q + 32'd1;
      if (pop_kill) perf_killed_q <= perf_killed_q + 32'd1;
    end
  end

  assign perf_done_o   = perf_done_q;
  assign perf_killed_o = perf_killed_q;
`endif

endmodule

// File: tb/tb_dummy_accel_mt_unit.sv
// Scoreboard bench for dummy_accel_mt_unit; honours DUMMY_ACCEL_PERF_CNT_EN when defined.
module tb_dummy_accel_mt_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic        issue_op_i = 1'b0;
  logic [3:0]  issue_id_i = '0;
  logic [4:0]  issue_rd_i = '0;
  logic [31:0] issue_rs1_i = '0;
  logic [11:0] issue_imm_i = '0;
  logic        commit_valid_i = 1'b0;
  logic [3:0]  commit_id_i = '0;
  logic        commit_kill_i = 1'b0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b1;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [31:0] result_data_o;
  logic        result_we_o;
  logic        busy_o;
`ifdef DUMMY_ACCEL_PERF_CNT_EN
  logic [31:0] perf_done_o, perf_killed_o;
`endif

  dummy_accel_mt_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_op_i(issue_op_i), .issue_id_i(issue_id_i), .issue_rd_i(issue_rd_i),
    .issue_rs1_i(issue_rs1_i), .issue_imm_i(issue_imm_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o),
    .result_data_o(result_data_o), .result_we_o(result_we_o),
    .busy_o(busy_o)
`ifdef DUMMY_ACCEL_PERF_CNT_EN
    , .perf_done_o(perf_done_o), .perf_killed_o(perf_killed_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int n_done = 0;

  function automatic logic [31:0] model(input logic op, input logic [31:0] rs1, input logic [11:0] imm);
    logic [31:0] se;
    se = {{20{imm[11]}}, imm};
    if (op) return rs1 << imm[4:0];
    return rs1 + se;
  endfunction

  task automatic expect_res(input logic [3:0] id, input logic [4:0] rd, input logic op,
                            input logic [31:0] rs1, input logic [11:0] imm);
    exp_t e;
    e.id = id; e.rd = rd; e.data = model(op, rs1, imm);
    sb.push_back(e);
  endtask

  // Result monitor: a handshake completes at the posedge following this negedge.
  always @(negedge clk_i) begin
    if (result_valid_o && result_ready_i) begin
      exp_t e;
      total++;
      n_done++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: got id=%0d data=%h, required none", result_id_o, result_data_o);
      end else begin
        e = sb.pop_front();
        if ({result_id_o, result_rd_o, result_data_o, result_we_o} !== {e.id, e.rd, e.data, 1'b1}) begin
          bad++;
          $display("FAIL result: got id=%0d rd=%0d data=%h we=%b, required id=%0d rd=%0d data=%h we=1",
                   result_id_o, result_rd_o, result_data_o, result_we_o, e.id, e.rd, e.data);
        end
      end
    end
  end

  task automatic issue(input logic op, input logic [3:0] id, input logic [4:0] rd,
                       input logic [31:0] rs1, input logic [11:0] imm,
                       input logic cm, input logic kill);
    issue_valid_i = 1'b1; issue_op_i = op; issue_id_i = id; issue_rd_i = rd;
    issue_rs1_i = rs1; issue_imm_i = imm;
    commit_valid_i = cm; commit_id_i = id; commit_kill_i = kill;
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0; commit_valid_i = 1'b0; commit_kill_i = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    @(posedge clk_i); #1;
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk_i);
      if (!busy_o) done = 1'b1;
    end
    total++;
    if (!done) begin bad++; $display("FAIL %s_idle_timeout: busy=%b, required 0", name, busy_o); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b, required 1", issue_ready_o); end
    total++; if (result_valid_o !== 1'b0 || result_we_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b/%b, required 0/0", result_valid_o, result_we_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
    total++; if ({result_data_o, result_id_o, result_rd_o} !== '0) begin bad++; $display("FAIL rst_outs: got %h/%0d/%0d, required 0", result_data_o, result_id_o, result_rd_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_add_latency();
    issue(1'b0, 4'd1, 5'd5, 32'd10, 12'hFFD, 1'b0, 1'b0);
    expect_res(4'd1, 5'd5, 1'b0, 32'd10, 12'hFFD);
    commit(4'd1, 1'b0);
    @(negedge clk_i);
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL add_lat0: got %b, required 0", result_valid_o); end
    @(posedge clk_i); @(negedge clk_i);
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL add_lat1: got %b, required 0", result_valid_o); end
    @(posedge clk_i); @(negedge clk_i);
    total++; if (result_valid_o !== 1'b1 || result_data_o !== 32'd7) begin bad++; $display("FAIL add_lat2: got valid=%b data=%0d, required 1/7", result_valid_o, result_data_o); end
    wait_idle("add");
  endtask

  task automatic test_full();
    bit got = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(1'b0, 4'(i), 5'(i + 8), 32'(100 * i), 12'(i), 1'b0, 1'b0);
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready: got %b, required 0", issue_ready_o); end
    expect_res(4'd0, 5'd8, 1'b0, 32'd0, 12'd0);
    commit(4'd0, 1'b0);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk_i);
      if (result_valid_o) got = 1'b1;
    end
    total++; if (!got || issue_ready_o !== 1'b0) begin bad++; $display("FAIL full_before_pop: got valid=%b ready=%b, required 1/0", got, issue_ready_o); end
    @(posedge clk_i); #1;
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL full_after_pop: got %b, required 1", issue_ready_o); end
    for (int i = 1; i < 4; i++) begin
      expect_res(4'(i), 5'(i + 8), 1'b0, 32'(100 * i), 12'(i));
      commit(4'(i), 1'b0);
    end
    wait_idle("full");
  endtask

  task automatic test_shl();
    expect_res(4'd4, 5'd3, 1'b1, 32'd1, 12'd5);
    issue(1'b1, 4'd4, 5'd3, 32'd1, 12'd5, 1'b1, 1'b0);
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL shl_early: got %b, required 0", result_valid_o); end
    @(posedge clk_i); @(negedge clk_i);
    total++; if (result_valid_o !== 1'b1 || result_data_o !== 32'd32) begin bad++; $display("FAIL shl_lat: got valid=%b data=%0d, required 1/32", result_valid_o, result_data_o); end
    wait_idle("shl5");
    expect_res(4'd5, 5'd4, 1'b1, 32'h0000ABCD, 12'd0);
    issue(1'b1, 4'd5, 5'd4, 32'h0000ABCD, 12'd0, 1'b1, 1'b0);
    wait_idle("shl0");
    expect_res(4'd6, 5'd6, 1'b1, 32'h80000003, 12'd33);
    issue(1'b1, 4'd6, 5'd6, 32'h80000003, 12'd33, 1'b1, 1'b0);
    wait_idle("shlmask");
    expect_res(4'd7, 5'd7, 1'b0, 32'hFFFFFFFF, 12'h7FF);
    issue(1'b0, 4'd7, 5'd7, 32'hFFFFFFFF, 12'h7FF, 1'b1, 1'b0);
    wait_idle("addwrap");
  endtask

  task automatic test_kill();
    issue(1'b0, 4'd2, 5'd1, 32'd5, 12'd1, 1'b0, 1'b0);
    issue(1'b0, 4'd3, 5'd2, 32'd6, 12'd2, 1'b0, 1'b0);
    commit(4'd2, 1'b1);
    expect_res(4'd3, 5'd2, 1'b0, 32'd6, 12'd2);
    commit(4'd3, 1'b0);
    wait_idle("kill");
    total++; if (sb.size() != 0) begin bad++; $display("FAIL kill_sb: got %0d pending, required 0", sb.size()); end
`ifdef DUMMY_ACCEL_PERF_CNT_EN
    total++; if (perf_killed_o !== 32'd1) begin bad++; $display("FAIL perf_killed: got %0d, required 1", perf_killed_o); end
    total++; if (perf_done_o !== 32'(n_done)) begin bad++; $display("FAIL perf_done: got %0d, required %0d", perf_done_o, n_done); end
`endif
    commit(4'd9, 1'b0);
    repeat (3) @(negedge clk_i);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL stray_commit: got busy=%b, required 0", busy_o); end
  endtask

  task automatic test_dup_id();
    issue(1'b0, 4'd5, 5'd1, 32'd1, 12'd1, 1'b0, 1'b0);
    expect_res(4'd5, 5'd1, 1'b0, 32'd1, 12'd1);
    issue(1'b0, 4'd5, 5'd2, 32'd10, 12'd10, 1'b1, 1'b0);
    expect_res(4'd5, 5'd2, 1'b0, 32'd10, 12'd10);
    commit(4'd5, 1'b0);
    wait_idle("dup");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      expect_res(4'(8 + i), 5'(20 + i), 1'(i & 1), 32'(3 + i), 12'(i + 1));
      issue(1'(i & 1), 4'(8 + i), 5'(20 + i), 32'(3 + i), 12'(i + 1), 1'b1, 1'b0);
    end
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_full: got %b, required 0", issue_ready_o); end
    wait_idle("b2b");
  endtask

  task automatic test_hold_reset();
    bit got = 1'b0;
    logic [41:0] snap;
    result_ready_i = 1'b0;
    issue(1'b0, 4'd7, 5'd9, 32'h00001000, 12'hFFF, 1'b1, 1'b0);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk_i);
      if (result_valid_o) got = 1'b1;
    end
    total++; if (!got || result_data_o !== 32'h00000FFF || result_id_o !== 4'd7) begin bad++; $display("FAIL hold_first: got valid=%b data=%h id=%0d, required 1/00000fff/7", got, result_data_o, result_id_o); end
    snap = {result_valid_o, result_id_o, result_rd_o, result_data_o};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      total++; if ({result_valid_o, result_id_o, result_rd_o, result_data_o} !== snap) begin bad++; $display("FAIL hold_stable: got %h, required %h", {result_valid_o, result_id_o, result_rd_o, result_data_o}, snap); end
    end
    #2 rst_i = 1'b1;
    #1;
    total++; if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL rst_mid: got valid=%b busy=%b, required 0/0", result_valid_o, busy_o); end
    total++; if (issue_ready_o !== 1'b1 || result_data_o !== '0) begin bad++; $display("FAIL rst_mid_outs: got ready=%b data=%h, required 1/0", issue_ready_o, result_data_o); end
`ifdef DUMMY_ACCEL_PERF_CNT_EN
    total++; if (perf_done_o !== '0 || perf_killed_o !== '0) begin bad++; $display("FAIL rst_perf: got %0d/%0d, required 0/0", perf_done_o, perf_killed_o); end
`endif
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    result_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    total++; if (busy_o !== 1'b0 || result_valid_o !== 1'b0) begin bad++; $display("FAIL post_rst: got busy=%b valid=%b, required 0/0", busy_o, result_valid_o); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_full();
    test_shl();
    test_kill();
    test_dup_id();
    test_back_to_back();
    test_hold_reset();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dummy_accel_mt_unit.md
DUMMY_ACCEL_MT_UNIT -- requirements
Module: dummy_accel_mt_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter IMM_WIDTH, default 12, immediate width; sign-extended to WIDTH.
REQ-003 SHALL have parameter ID_WIDTH, default 4, instruction tag width.
REQ-004 SHALL have parameter DEPTH, default 4, in-flight entry count; power of two, at least 2.
REQ-005 SHALL have port clk_i, input, 1 bit, the only clock; all state on rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have issue_valid_i (input, 1) and issue_ready_o (output, 1): issue handshake.
REQ-008 SHALL have issue_op_i, input, 1 bit: 0 = ADD, 1 = SHL.
REQ-009 SHALL have issue_id_i (input, ID_WIDTH) and issue_rd_i (input, 5): tag and destination register.
REQ-010 SHALL have issue_rs1_i (input, WIDTH) and issue_imm_i (input, IMM_WIDTH): operands.
REQ-011 SHALL have commit_valid_i (input, 1), commit_id_i (input, ID_WIDTH) and commit_kill_i (input, 1): commit channel, no ready.
REQ-012 SHALL have result_valid_o (output, 1) and result_ready_i (input, 1): result handshake.
REQ-013 SHALL have result_id_o (output, ID_WIDTH), result_rd_o (output, 5), result_data_o (output, WIDTH) and result_we_o (output, 1).
REQ-014 SHALL have busy_o, output, 1 bit: high when any entry is occupied or the FSM is not IDLE.

Function
REQ-015 SHALL hold a DEPTH-entry circular buffer with head and tail pointers plus a count, in issue order; each entry stores op, id, rd, rs1, imm and state PENDING, COMMITTED or KILLED.
REQ-016 SHALL drive issue_ready_o = (count < DEPTH); an entry is allocated at tail as PENDING on issue_valid_i && issue_ready_o.
REQ-017 On commit_valid_i, the commit SHALL apply to the oldest PENDING entry whose id equals commit_id_i, marking it KILLED if commit_kill_i, else COMMITTED.
REQ-018 A commit that matches no PENDING entry SHALL be ignored.
REQ-019 A commit arriving in the same cycle as an allocation with an equal id, and with no older PENDING match, SHALL apply to the new entry.
REQ-020 The execution FSM SHALL have states IDLE, EXEC and RESP.
REQ-021 In IDLE with a KILLED head, the head SHALL be popped in 1 cycle with no result; with a COMMITTED head, the FSM SHALL load the operands and enter EXEC; with a PENDING head or an empty buffer, it SHALL stay in IDLE.
REQ-022 ADD SHALL compute rs1 + sext(imm) modulo 2^WIDTH in 1 EXEC cycle.
REQ-023 SHL SHALL shift rs1 left by 1 bit per EXEC cycle for imm[4:0] cycles, using 1 cycle when imm[4:0] = 0; the count is masked to clog2(WIDTH) bits.
REQ-024 In RESP, result_valid_o SHALL be high and all result outputs stable until result_ready_i; on that handshake the head SHALL be popped and the FSM SHALL return to IDLE.
REQ-025 result_we_o SHALL equal result_valid_o.
REQ-026 Minimum latency from commit to result_valid_o SHALL be 2 cycles (IDLE, EXEC), given a committed head and an idle FSM.
REQ-027 Allocation and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-028 Results SHALL be produced in issue order only.

Reset
REQ-029 While rst_i is high, count and pointers SHALL be 0, the FSM in IDLE, all entries invalid, and issue_ready_o=1, result_valid_o=0, result_we_o=0, busy_o=0, with result data, id and rd all 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight entries and any pending result immediately.

Configuration
REQ-031 With macro DUMMY_ACCEL_PERF_CNT_EN defined, the block SHALL add 32-bit outputs perf_done_o and perf_killed_o, reset to 0, counting result handshakes and KILLED pops respectively, and wrapping at 2^32.
REQ-032 Without DUMMY_ACCEL_PERF_CNT_EN, these ports and counters SHALL NOT exist.

Verification
REQ-033 Scenario: issue ADD id=1 rs1=10 imm=-3, commit id=1 on the next cycle -> result 7, id 1, result_valid_o 2 cycles after commit.
REQ-034 Scenario: issue 4 entries with ids 0-3 and no commit -> issue_ready_o=0 on the cycle after the 4th allocation; commit id 0 -> its result is produced and issue_ready_o returns to 1 after the pop.
REQ-035 Scenario: issue SHL rs1=1 imm=5 with commit in the same cycle as issue -> result 32 after 5 EXEC cycles.
REQ-036 Scenario: issue ids 2 and 3, kill id 2, commit id 3 -> only id 3 is returned; perf_killed_o=1 when the macro is enabled.
REQ-037 Scenario: hold result_ready_i=0 for 3 cycles -> result outputs stable throughout; assert rst_i mid-hold -> result_valid_o=0 and busy_o=0 at once.
